// File: rtl/arb_defs_pkg.sv
// rtl/arb_defs_pkg.sv - shared encodings for the RAM port arbiter
package arb_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_OWN0 = 3'b010,
        ST_OWN1 = 3'b100
    } arb_state_t;

    localparam logic PORT0_ID = 1'b0;
    localparam logic PORT1_ID = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// rtl/ram_port_arbiter_rd_tag_pipe.sv - RD_LAT-deep {valid,id} delay line for read-return routing
module rd_tag_pipe
    import arb_defs_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    CLK,
    input  logic    RESET,
    input  rd_tag_t push_tag,
    output rd_tag_t pop_tag
);

    rd_tag_t stage_q [RD_LAT];

    // Reset drops every tag in flight so no stale rvalid survives it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign pop_tag = stage_q[RD_LAT-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin, burst-bounded arbiter sharing one RAM port
// between the ADMA engine (port 0) and the host path (port 1).
module ram_port_arbiter
    import arb_defs_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1,
    parameter int AW        = 64,
    parameter int DW        = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_address,
    output logic          ram_read,
    output logic          ram_write,
    output logic [DW-1:0] data_to_ram,
    input  logic [DW-1:0] data_from_ram,
    output logic          busy
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          last_owner_q;
    logic [CW-1:0] beat_cnt_q;
    logic          burst_done;
    rd_tag_t       push_tag;
    rd_tag_t       pop_tag;

    assign burst_done = (beat_cnt_q == BURST_LAST);

    // Next-state and grants. The other port only preempts at the burst limit.
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                gnt0 = req0;
                if (!req0) begin
                    state_d = req1 ? ST_OWN1 : ST_IDLE;
                end else if (burst_done && req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN1: begin
                gnt1 = req1;
                if (!req1) begin
                    state_d = req0 ? ST_OWN0 : ST_IDLE;
                end else if (burst_done && req0) begin
                    state_d = ST_OWN0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                beat_cnt_q <= '0;
                if (state_d == ST_OWN0) begin
                    last_owner_q <= PORT0_ID;
                end else if (state_d == ST_OWN1) begin
                    last_owner_q <= PORT1_ID;
                end
            end else if ((gnt0 || gnt1) && !burst_done) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        ram_address = '0;
        data_to_ram = '0;
        ram_read    = 1'b0;
        ram_write   = 1'b0;
        case (state_q)
            ST_OWN0: begin
                ram_address = addr0;
                data_to_ram = wdata0;
                ram_read    = req0 & ~we0;
                ram_write   = req0 & we0;
            end
            ST_OWN1: begin
                ram_address = addr1;
                data_to_ram = wdata1;
                ram_read    = req1 & ~we1;
                ram_write   = req1 & we1;
            end
            default: begin
                ram_address = '0;
            end
        endcase
    end

    // Tag each read with its issuer so returns route correctly across handoffs.
    assign push_tag.valid = ram_read;
    assign push_tag.id    = (state_q == ST_OWN1) ? PORT1_ID : PORT0_ID;

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .CLK      (CLK),
        .RESET    (RESET),
        .push_tag (push_tag),
        .pop_tag  (pop_tag)
    );

    assign rvalid0 = pop_tag.valid & (pop_tag.id == PORT0_ID);
    assign rvalid1 = pop_tag.valid & (pop_tag.id == PORT1_ID);
    assign rdata0  = data_from_ram;
    assign rdata1  = data_from_ram;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;

    localparam int MAX_BURST = 16;
    localparam int RD_LAT    = 1;
    localparam int AW        = 64;
    localparam int DW        = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_address;
    logic          ram_read, ram_write;
    logic [DW-1:0] data_to_ram;
    logic [DW-1:0] data_from_ram = '0;
    logic          busy;

    ram_port_arbiter #(
        .MAX_BURST (MAX_BURST),
        .RD_LAT    (RD_LAT),
        .AW        (AW),
        .DW        (DW)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req0          (req0),
        .we0           (we0),
        .addr0         (addr0),
        .wdata0        (wdata0),
        .req1          (req1),
        .we1           (we1),
        .addr1         (addr1),
        .wdata1        (wdata1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .rvalid0       (rvalid0),
        .rvalid1       (rvalid1),
        .rdata0        (rdata0),
        .rdata1        (rdata1),
        .ram_address   (ram_address),
        .ram_read      (ram_read),
        .ram_write     (ram_write),
        .data_to_ram   (data_to_ram),
        .data_from_ram (data_from_ram),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM model: unwritten locations read back a recognisable pattern.
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] ram_init(input logic [AW-1:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(posedge CLK) begin
        if (ram_write) mem[ram_address] = data_to_ram;
        if (ram_read) data_from_ram <= mem.exists(ram_address) ? mem[ram_address] : ram_init(ram_address);
    end

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RESET) begin
            if (gnt0 && gnt1) check("dual_gnt", 64'(1), 64'(0));
            if (rvalid0 && rvalid1) check("dual_rvalid", 64'(1), 64'(0));
            if (rvalid0) begin
                if (q0.size() == 0) begin
                    check("rvalid0_unexpected", 64'(1), 64'(0));
                end else begin
                    e = q0.pop_front();
                    check("rdata0", 64'(rdata0), 64'(e.data));
                    check("rvalid0_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (rvalid1) begin
                if (q1.size() == 0) begin
                    check("rvalid1_unexpected", 64'(1), 64'(0));
                end else begin
                    e = q1.pop_front();
                    check("rdata1", 64'(rdata1), 64'(e.data));
                    check("rvalid1_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drop(input int p);
        if (p == 0) begin
            req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        end else begin
            req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        end
    endtask

    // Presents one beat, waits for its grant, and queues the read response.
    task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_data, output int waits, output int gcyc);
        logic g;
        exp_t e;
        if (p == 0) begin
            req0 = 1; we0 = w; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1; we1 = w; addr1 = a; wdata1 = wd;
        end
        waits = 0;
        g = 0;
        while (!g && waits < 200) begin
            @(negedge CLK);
            g = (p == 0) ? gnt0 : gnt1;
            if (!g) waits++;
        end
        gcyc = cyc;
        check($sformatf("grant_seen_port%0d", p), 64'(g), 64'(1));
        if (g && !w) begin
            e.data = exp_data;
            e.cyc  = cyc + RD_LAT;
            if (p == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        tick();
    endtask

    task automatic pulse_reset();
        RESET = 1;
        tick();
        RESET = 0;
    endtask

    int w0v, g0v, w1v, g1v, g0_last, g1_first, n, k, who;
    int run_who[$];
    int run_len[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        RESET = 1;
        drop(0);
        drop(1);
        repeat (3) tick();
        RESET = 0;
        @(negedge CLK);
        check("reset_flags", 64'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_read, ram_write}), 64'(0));
        check("reset_bus", ram_address | 64'(data_to_ram), 64'(0));
        tick();

        // Three reads by port 0: one arbitration cycle, then back-to-back grants.
        issue(0, 0, 64'h100, '0, 32'hC0DE0100, w0v, g0v);
        check("t1_arb_wait", 64'(w0v), 64'(1));
        issue(0, 0, 64'h104, '0, 32'hC0DE0104, w0v, g0v);
        check("t1_beat2_wait", 64'(w0v), 64'(0));
        issue(0, 0, 64'h108, '0, 32'hC0DE0108, w0v, g0v);
        check("t1_beat3_wait", 64'(w0v), 64'(0));
        drop(0);
        repeat (3) tick();
        check("t1_drained", 64'(q0.size()), 64'(0));

        // Tie after reset goes to port 0; dropping req0 hands straight to port 1.
        pulse_reset();
        req0 = 1; we0 = 1; addr0 = 64'h80; wdata0 = 32'h11111111;
        req1 = 1; we1 = 1; addr1 = 64'h40; wdata1 = 32'hDEADBEEF;
        @(negedge CLK);
        check("t2_idle_no_gnt", 64'({gnt0, gnt1}), 64'(0));
        tick();
        @(negedge CLK);
        check("t2_own0_first", 64'({gnt0, gnt1, ram_write}), 64'(3'b101));
        check("t2_w0_addr", ram_address, 64'h80);
        tick();
        drop(0);
        @(negedge CLK);
        check("t2_no_idle_bubble", 64'({busy, gnt0, gnt1}), 64'(3'b100));
        tick();
        @(negedge CLK);
        check("t2_own1", 64'({gnt0, gnt1, ram_write}), 64'(3'b011));
        check("t2_w1_addr", ram_address, 64'h40);
        check("t2_w1_data", 64'(data_to_ram), 64'(32'hDEADBEEF));
        tick();
        drop(1);
        repeat (2) tick();
        check("t2_idle_after", 64'(busy), 64'(0));

        // Port 0 reads back what port 1 wrote.
        issue(0, 0, 64'h40, '0, 32'hDEADBEEF, w0v, g0v);
        drop(0);
        repeat (3) tick();

        // Burst limit: 16 beats per owner while the other keeps requesting.
        req0 = 1; we0 = 1; addr0 = 64'h600; wdata0 = 32'h1;
        n = 0;
        k = 0;
        while (n < 5 && k < 100) begin
            @(negedge CLK);
            if (gnt0) n++;
            k++;
        end
        check("t3_first5", 64'(n), 64'(5));
        tick();
        req1 = 1; we1 = 1; addr1 = 64'h700; wdata1 = 32'h2;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            who = (gnt0 && !gnt1) ? 0 : ((gnt1 && !gnt0) ? 1 : 2);
            if (run_who.size() > 0 && run_who[run_who.size()-1] == who) begin
                run_len[run_len.size()-1]++;
            end else begin
                run_who.push_back(who);
                run_len.push_back(1);
            end
        end
        check("t3_runs_ge3", 64'(run_who.size() >= 3), 64'(1));
        if (run_who.size() >= 3) begin
            check("t3_run0_owner", 64'(run_who[0]), 64'(0));
            check("t3_run0_len", 64'(run_len[0]), 64'(11));
            check("t3_run1_owner", 64'(run_who[1]), 64'(1));
            check("t3_run1_len", 64'(run_len[1]), 64'(16));
            check("t3_run2_owner", 64'(run_who[2]), 64'(0));
            check("t3_run2_len", 64'(run_len[2]), 64'(16));
        end
        tick();
        drop(0);
        drop(1);
        repeat (2) tick();

        // Port 0's 16th beat is a read that completes after the handoff to port 1.
        g0_last = -1;
        g1_first = -100;
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    issue(0, 0, 64'h200 + 64'(4 * i), '0, ram_init(64'h200 + 64'(4 * i)), w0v, g0v);
                    if (i == 15) g0_last = g0v;
                end
                drop(0);
            end
            begin
                repeat (3) tick();
                issue(1, 0, 64'h300, '0, 32'hC0DE0300, w1v, g1v);
                g1_first = g1v;
                issue(1, 0, 64'h304, '0, 32'hC0DE0304, w1v, g1v);
                drop(1);
            end
        join
        check("t4_handoff_adjacent", 64'(g1_first), 64'(g0_last + 1));
        repeat (3) tick();
        check("t4_drained", 64'(q0.size() + q1.size()), 64'(0));

        // Reset with a read beat in flight: the return is dropped and the tie resets to port 0.
        req0 = 1; we0 = 0; addr0 = 64'h500;
        @(negedge CLK);
        check("t5_arb_cycle", 64'(gnt0), 64'(0));
        tick();
        RESET = 1;
        @(negedge CLK);
        check("t5_read_in_flight", 64'({gnt0, ram_read}), 64'(2'b11));
        tick();
        RESET = 0;
        req0 = 1; we0 = 1; addr0 = 64'h510; wdata0 = 32'h5;
        req1 = 1; we1 = 1; addr1 = 64'h520; wdata1 = 32'h6;
        @(negedge CLK);
        check("t5_no_rvalid", 64'({rvalid0, rvalid1}), 64'(0));
        check("t5_idle_flags", 64'({gnt0, gnt1, busy, ram_read, ram_write}), 64'(0));
        check("t5_idle_bus", ram_address | 64'(data_to_ram), 64'(0));
        tick();
        @(negedge CLK);
        check("t5_tie_port0", 64'({gnt0, gnt1}), 64'(2'b10));
        tick();
        drop(0);
        drop(1);
        repeat (3) tick();

        check("sb_empty", 64'(q0.size() + q1.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
